multicycle_sequencer: RTL

- Moore/Mealy control FSM that sequences the instruction-decode datapath (decoder, register file, sign extender, control unit) through fetch, decode, execute, memory and writeback.
- Gates the control unit's RegWrite/MemRead/MemWrite into single-cycle strobes.
- Handshakes with instruction and data memory, with timeout detection.
- Handles halt requests at instruction boundaries and counts retired instructions.

---
 rtl/multicycle_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: walks the decode datapath through fetch/decode/execute/
// memory/writeback, turns control-unit levels into single-cycle strobes, guards memory waits.
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             branch,
  input  logic             branch_taken,
  input  logic             halt_req,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_en,
  output logic             rf_we,
  output logic             pc_en,
  output logic             pc_sel,
  output logic [2:0]       state,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned TMO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_ERROR     = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               retire_c;
  logic               wait_c;
  logic               expired_c;
  logic               ir_en_c;
  logic               pc_sel_c;

  // State, timeout counter and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, Mealy strobes and counter updates
  always_comb begin
    state_d   = state_q;
    retire_c  = 1'b0;
    wait_c    = 1'b0;
    ir_en_c   = 1'b0;
    pc_sel_c  = 1'b0;
    expired_c = (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_en_c = 1'b1;
          state_d = S_DECODE;
        end else if (expired_c) begin
          state_d = S_ERROR;
        end else begin
          wait_c = 1'b1;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (MemRead && MemWrite) begin
          state_d = S_ERROR;
        end else if (MemRead || MemWrite) begin
          state_d = S_MEMORY;
        end else if (RegWrite) begin
          state_d = S_WRITEBACK;
        end else begin
          retire_c = 1'b1;
          pc_sel_c = branch & branch_taken;
        end
      end
      S_MEMORY: begin
        if (dmem_ack) begin
          if (RegWrite) state_d = S_WRITEBACK;
          else          retire_c = 1'b1;
        end else if (expired_c) begin
          state_d = S_ERROR;
        end else begin
          wait_c = 1'b1;
        end
      end
      S_WRITEBACK: retire_c = 1'b1;
      S_HALT: begin
        if (!halt_req) state_d = S_FETCH;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase

    // halt_req only matters at an instruction boundary
    if (retire_c) state_d = halt_req ? S_HALT : S_FETCH;

    // wait_c implies staying in the same state, so any transition clears the counter
    tmo_d = wait_c ? tmo_q + TMO_W'(1) : '0;
    cnt_d = retire_c ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Outputs are forced low for as long as reset is held
  assign imem_req    = !rst && (state_q == S_FETCH);
  assign dmem_req    = !rst && (state_q == S_MEMORY);
  assign dmem_we     = !rst && (state_q == S_MEMORY) && MemWrite;
  assign rf_we       = !rst && (state_q == S_WRITEBACK);
  assign error       = !rst && (state_q == S_ERROR);
  assign ir_en       = !rst && ir_en_c;
  assign pc_en       = !rst && retire_c;
  assign pc_sel      = !rst && retire_c && pc_sel_c;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule
